// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the load/store unit: funct3 load/store size
// encodings and the LSU state type.
package riscv_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BUS   = 2'd1,
        LSU_RDATA = 2'd2,
        LSU_DONE  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: byte enables and lane-replicated store data,
// load extract with sign/zero extension, and misalignment detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  sel_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata_i[{off_i, 3'b000} +: 8];
        rd_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // sel_i[1:0] carries the size and sel_i[2] the unsigned flag; the
    // undefined encodings 011/110/111 all land in the word branch.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (sel_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = sel_i[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                be_o         = 4'b0011 << {off_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = sel_i[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                misaligned_o = off_i[0];
            end
            default: begin
                misaligned_o = (off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: req/gnt/rvalid data-memory transaction FSM.
// Optional LSU_MISALIGN_CHECK_EN: misaligned requests complete with err_o=1 without a bus access.
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              memRW_i,
    input  logic [2:0]        ld_st_sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    // Handshake: a request is accepted on a clock edge where req_valid_i and
    // req_ready_o are both high; the bus request is held until dmem_gnt_i.
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [2:0]        al_sel;
    logic [1:0]        al_off;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              al_misaligned;

    // In IDLE the lane logic looks at the incoming request so misalignment
    // can be judged at accept time; afterwards it works on the latched copy.
    always_comb begin
        al_sel = (state_q == LSU_IDLE) ? ld_st_sel_i : sel_q;
        al_off = (state_q == LSU_IDLE) ? addr_i[1:0] : addr_q[1:0];
    end

    lsu_align u_align (
        .sel_i        (al_sel),
        .off_i        (al_off),
        .wdata_i      (wdata_q),
        .rdata_i      (dmem_rdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_misaligned;
    assign unused_misaligned = al_misaligned;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    we_d    = memRW_i;
                    sel_d   = ld_st_sel_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = LSU_BUS;
`ifdef LSU_MISALIGN_CHECK_EN
                    err_d   = al_misaligned;
                    if (al_misaligned) begin
                        state_d = LSU_DONE;
                    end
`endif
                end
            end
            LSU_BUS: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? LSU_DONE : LSU_RDATA;
                end
            end
            LSU_RDATA: begin
                if (dmem_rvalid_i) begin
                    rdata_d = al_rdata;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            sel_q   <= LS_W;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Bus outputs are zero outside BUS so reset drops them combinationally.
    always_comb begin
        req_ready_o  = (state_q == LSU_IDLE);
        rsp_valid_o  = (state_q == LSU_DONE);
        rdata_o      = rdata_q;
        dmem_req_o   = (state_q == LSU_BUS);
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        if (state_q == LSU_BUS) begin
            dmem_we_o    = we_q;
            dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
            dmem_be_o    = al_be;
            dmem_wdata_o = al_wdata;
        end
`ifdef LSU_MISALIGN_CHECK_EN
        err_o = (state_q == LSU_DONE) && err_q;
`else
        err_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table of accesses applied with fixed and random
// bus stalls, plus hand-written stall and mid-transaction reset sequences.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        memRW_i;
    logic [2:0]  ld_st_sel_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    lsu dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .memRW_i       (memRW_i),
        .ld_st_sel_i   (ld_st_sel_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        logic [3:0]  be;
        logic [31:0] bus_wdata;
        logic [31:0] exp_rdata;
        logic        mis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    logic [32:0] exp_q[$];
    logic [31:0] last_rdata;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every completion pops one expected {err, rdata}
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid_o=1 expected no response at %0t", $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rdata_o, e[31:0]);
                chk("rsp_err", {31'b0, err_o}, {31'b0, e[32]});
            end
        end
    end

    task automatic chk_bus(input vec_t v);
        chk("dmem_req", {31'b0, dmem_req_o}, 32'd1);
        chk("dmem_we", {31'b0, dmem_we_o}, {31'b0, v.we});
        chk("dmem_addr", dmem_addr_o, v.addr & 32'hFFFF_FFFC);
        chk("dmem_be", {28'b0, dmem_be_o}, {28'b0, v.be});
        if (v.we) chk("dmem_wdata", dmem_wdata_o, v.bus_wdata);
        chk("ready_busy", {31'b0, req_ready_o}, 32'd0);
        chk("rsp_early", {31'b0, rsp_valid_o}, 32'd0);
    endtask

    // driver: one access with gd gnt-stall and rd rvalid-stall cycles
    task automatic do_access(input vec_t v, input int gd, input int rd);
        bit skip;
        skip = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        skip = v.mis;
`endif
        @(negedge clk_i);
        chk("ready_idle", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        memRW_i     = v.we;
        ld_st_sel_i = v.sel;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        if (skip) begin
            exp_q.push_back({1'b1, last_rdata});
        end else if (v.we) begin
            exp_q.push_back({1'b0, last_rdata});
        end else begin
            last_rdata = v.exp_rdata;
            exp_q.push_back({1'b0, v.exp_rdata});
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        memRW_i     = 1'($urandom_range(0, 1));
        ld_st_sel_i = 3'($urandom_range(0, 7));
        addr_i      = $urandom;
        wdata_i     = $urandom;
        @(negedge clk_i);
        if (skip) begin
            chk("skip_no_req", {31'b0, dmem_req_o}, 32'd0);
            chk("skip_rsp", {31'b0, rsp_valid_o}, 32'd1);
            return;
        end
        for (int i = 0; i < gd; i++) begin
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = $urandom;
            chk_bus(v);
            @(negedge clk_i);
        end
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b0;
        chk_bus(v);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        if (!v.we) begin
            for (int i = 0; i < rd; i++) begin
                dmem_gnt_i    = 1'b1;
                dmem_rvalid_i = 1'b0;
                chk("rdata_wait_req", {31'b0, dmem_req_o}, 32'd0);
                chk("rdata_wait_rsp", {31'b0, rsp_valid_o}, 32'd0);
                chk("rdata_wait_ready", {31'b0, req_ready_o}, 32'd0);
                @(negedge clk_i);
            end
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = v.bus_rdata;
            chk("rvalid_rsp_early", {31'b0, rsp_valid_o}, 32'd0);
            @(negedge clk_i);
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
        end
        chk("rsp_on_time", {31'b0, rsp_valid_o}, 32'd1);
        chk("ready_in_done", {31'b0, req_ready_o}, 32'd0);
        chk("no_req_in_done", {31'b0, dmem_req_o}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
        chk({tag, "_rsp"}, {31'b0, rsp_valid_o}, 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        chk({tag, "_err"}, {31'b0, err_o}, 32'd0);
        chk({tag, "_req"}, {31'b0, dmem_req_o}, 32'd0);
        chk({tag, "_we"}, {31'b0, dmem_we_o}, 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, 32'd0);
        chk({tag, "_be"}, {28'b0, dmem_be_o}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_rdata = 32'd0;
        //              we    sel     addr          wdata         bus_rdata     be       bus_wdata     exp_rdata     mis
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0,        32'h0000_0080, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h9ABC_1234, 4'b1100, 32'h0,        32'hFFFF_9ABC, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h9ABC_1234, 4'b1100, 32'h0,        32'h0000_9ABC, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h5555_AAAA, 32'h0,        4'b1100, 32'hAAAA_AAAA, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 4'b0001, 32'h0,        32'h0000_007F, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_8001, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_0204, 32'h0,        32'h1357_9BDF, 4'b1111, 32'h0,        32'h1357_9BDF, 1'b0};
        vecs[11] = '{1'b1, 3'b111, 32'h0000_0208, 32'h0102_0304, 32'h0,        4'b1111, 32'h0102_0304, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h1122_3344, 4'b1111, 32'h0,        32'h1122_3344, 1'b1};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0000_F00F, 4'b0011, 32'h0,        32'hFFFF_F00F, 1'b1};
        vecs[14] = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h00AB_0000, 4'b0100, 32'h0,        32'h0000_00AB, 1'b0};

        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        memRW_i       = 1'b0;
        ld_st_sel_i   = 3'b000;
        addr_i        = 32'd0;
        wdata_i       = 32'd0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // pass 1: zero-stall bus
        for (int i = 0; i < NVEC; i++) do_access(vecs[i], 0, 0);
        // pass 2: random gnt/rvalid stalls
        for (int i = 0; i < NVEC; i++) do_access(vecs[i], $urandom_range(0, 3), $urandom_range(0, 3));
        // gnt stalled 3 cycles, rvalid 2 cycles: completion lands 8 cycles after accept
        do_access(vecs[7], 3, 2);

        // reset while waiting in RDATA; a late rvalid must be ignored
        @(negedge clk_i);
        req_valid_i = 1'b1;
        memRW_i     = 1'b0;
        ld_st_sel_i = 3'b010;
        addr_i      = 32'h0000_0300;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_seq_req", {31'b0, dmem_req_o}, 32'd1);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        chk("rst_seq_in_rdata", {31'b0, req_ready_o}, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("async_rst");
        last_rdata = 32'd0;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk_all_zero("late_rvalid");
        @(negedge clk_i);
        chk("late_rvalid_rsp2", {31'b0, rsp_valid_o}, 32'd0);

        // store-only history after reset keeps rdata_o at zero
        do_access(vecs[0], 1, 0);
        do_access(vecs[2], 0, 1);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core. It sits directly downstream of `control_logic` and consumes its `memRW_o` and `ld_st_sel_o` outputs, together with the ALU-computed address and the rs2 data. It runs a request/grant/rvalid transaction on the data-memory bus, applies byte lanes and sign/zero extension, and returns load data to the write-back mux (`wb_sel` = 00).

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; only 32 is supported.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: a memory instruction is presented.
- `req_ready_o` out 1: LSU can accept; high only in IDLE.
- `memRW_i` in 1: 1 = store, 0 = load (from `control_logic`).
- `ld_st_sel_i` in 3: funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr_i` in ADDR_W: effective byte address.
- `wdata_i` in DATA_W: store data (rs2).
- `rsp_valid_o` out 1: one-cycle completion pulse, for loads and stores.
- `rdata_o` out DATA_W: extended load data; valid with `rsp_valid_o`.
- `err_o` out 1: misaligned access; valid with `rsp_valid_o`.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: bus write enable.
- `dmem_addr_o` out ADDR_W: word-aligned address (bits [1:0] = 0).
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out DATA_W: lane-replicated write data.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in DATA_W: read data.

## Operation
- FSM states: IDLE, BUS, RDATA, DONE.
- IDLE: `req_ready_o`=1. On `req_valid_i`, latch `memRW`, `ld_st_sel`, `addr` and `wdata`, then go to BUS.
- BUS: `dmem_req_o`=1. All `dmem_*` outputs are driven from the latched request and stay stable until `dmem_gnt_i`.
  - Store + gnt: go to DONE.
  - Load + gnt: go to RDATA.
- RDATA: wait for `dmem_rvalid_i`. Register the extracted data, then go to DONE.
- DONE: `rsp_valid_o`=1 for exactly one cycle, then go to IDLE.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1],1'b0}.
  - W: 1111.
- Write data: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W unchanged.
- Load extract: select the byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Undefined sizes 011, 110, 111 are treated as W.
- Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
- `dmem_rvalid_i` is ignored in every state except RDATA.
- `dmem_gnt_i` is ignored outside BUS.

## Timing
- Reset values: state IDLE, `req_ready_o`=1. All other outputs are 0: `rsp_valid_o`, `rdata_o`, `err_o`, `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`.
- Reset is asynchronous. Asserting it mid-transaction drops `dmem_req_o` immediately. A late `rvalid` arriving after reset is ignored.
- Minimum store latency is 2 cycles from accept to `rsp_valid_o`: accept at cycle 0, req+gnt at 1, rsp at 2.
- Minimum load latency is 3 cycles: accept at 0, req+gnt at 1, rvalid at 2, rsp at 3.
- Each extra gnt or rvalid stall cycle adds one cycle.
- No new request is accepted until the cycle after DONE. Throughput is at most one access per 3 cycles (store) or 4 cycles (load).
- `rdata_o` holds its last value until the next load completes. It is 0 after a store-only history.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A misaligned request goes IDLE→DONE without touching the bus.
  - `rsp_valid_o`=1, `err_o`=1, `rdata_o` unchanged.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - `err_o` is tied to 0.
  - Misaligned accesses proceed using the natural lane of the low address bits; H with addr[0]=1 uses lanes per {addr[1],0}.

## Structure
- Shared package `riscv_pkg` holds:
  - the `ld_st_sel` encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - `lsu_state_e`.
- Sub-module `lsu_align`: combinational byte-enable/write-data generation plus load extract/extend, instantiated once.
- The FSM and registers live in `lsu`.

## Test plan
- SW at addr 0x100, wdata 0xDEADBEEF, gnt same cycle → `dmem_addr_o`=0x100, `be`=1111, `we`=1, `rsp_valid_o` 2 cycles after accept.
- LB at addr 0x103, rdata 0x80112233 → `be`=1000, `rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH at addr 0x102, rdata 0x9ABC1234 → 0xFFFF9ABC. LHU → 0x00009ABC. SH at 0x102, wdata 0x5555AAAA → `be`=1100, `wdata`=0xAAAAAAAA.
- Load with gnt delayed 3 cycles and rvalid delayed 2 cycles → `dmem_*` stable while waiting, `rsp_valid_o` at cycle 8, `req_ready_o` low throughout.
- LW at addr 0x102:
  - with `LSU_MISALIGN_CHECK_EN` → no `dmem_req_o`, `err_o`=1 one cycle after accept;
  - without it → bus read at 0x100, `err_o`=0.
- `rst_ni` low while in RDATA, then rvalid arrives → outputs zero immediately, no `rsp_valid_o`, `req_ready_o`=1.
